// File: rtl/dcache_assoc_if.sv
// dcache_assoc_if: CPU load/store port and block-wide memory port of the data cache
interface dcache_assoc_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int BLOCK_WORDS = 4
);
  localparam int OFF_W = $clog2(BLOCK_WORDS);
  logic read;
  logic write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] cpu_writeData;
  logic [DATA_W-1:0] cpu_readData;
  logic busywait;
  logic mem_read;
  logic mem_write;
  logic [ADDR_W-OFF_W-1:0] mem_address;
  logic [BLOCK_WORDS*DATA_W-1:0] mem_writedata;
  logic [BLOCK_WORDS*DATA_W-1:0] mem_readdata;
  logic mem_busywait;
  modport slave (
    input read, write, address, cpu_writeData, mem_readdata, mem_busywait,
    output cpu_readData, busywait, mem_read, mem_write, mem_address, mem_writedata
  );
  modport master (
    output read, write, address, cpu_writeData, mem_readdata, mem_busywait,
    input cpu_readData, busywait, mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/dcache_assoc.sv
// dcache_assoc: two-way set-associative write-back write-allocate data cache with per-set LRU
module dcache_assoc #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int BLOCK_WORDS = 4,
  parameter int SETS = 4
) (
  input logic clock_i,
  input logic reset_i,
  dcache_assoc_if.slave bus_io
);
  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int BLK_W = BLOCK_WORDS * DATA_W;
  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_e;
  state_e state_q, state_d;
  logic [BLK_W-1:0] data_q [SETS][2];
  logic [TAG_W-1:0] tag_q [SETS][2];
  logic [SETS-1:0][1:0] valid_q, dirty_q;
  logic [SETS-1:0] lru_q;
  logic [TAG_W-1:0] miss_tag_q;
  logic [IDX_W-1:0] miss_idx_q;
  logic vic_q;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off;
  logic hit0, hit1, hit, hway, victim, req, idle, mem_done;
  assign tag = bus_io.address[ADDR_W-1:IDX_W+OFF_W];
  assign idx = bus_io.address[IDX_W+OFF_W-1:OFF_W];
  assign off = bus_io.address[OFF_W-1:0];
  assign hit0 = valid_q[idx][0] && tag_q[idx][0] == tag;
  assign hit1 = valid_q[idx][1] && tag_q[idx][1] == tag;
  assign hit = hit0 || hit1;
  assign hway = hit1;
  assign victim = !valid_q[idx][0] ? 1'b0 : !valid_q[idx][1] ? 1'b1 : lru_q[idx];
  assign req = bus_io.read || bus_io.write;
  assign idle = state_q == IDLE;
  assign mem_done = !bus_io.mem_busywait;
  assign bus_io.busywait = reset_i && (idle ? req && !hit : 1'b1);
  assign bus_io.cpu_readData = (reset_i && bus_io.read && hit && idle) ? data_q[idx][hway][off*DATA_W +: DATA_W] : '0;
  assign bus_io.mem_read = state_q == FETCH;
  assign bus_io.mem_write = state_q == WRITEBACK;
  // Request address and data come only from latched miss state, never the live CPU address.
  assign bus_io.mem_address = (state_q == WRITEBACK) ? {tag_q[miss_idx_q][vic_q], miss_idx_q} : {miss_tag_q, miss_idx_q};
  assign bus_io.mem_writedata = data_q[miss_idx_q][vic_q];
  always_comb begin
    state_d = state_q;
    if (idle && req && !hit)
      state_d = (valid_q[idx][victim] && dirty_q[idx][victim]) ? WRITEBACK : FETCH;
    else if (state_q == WRITEBACK && mem_done)
      state_d = FETCH;
    else if (state_q == FETCH && mem_done)
      state_d = IDLE;
  end
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      lru_q <= '0;
    end else begin
      state_q <= state_d;
      if (idle && req && hit) begin
        lru_q[idx] <= !hway;
        if (bus_io.write) begin
          data_q[idx][hway][off*DATA_W +: DATA_W] <= bus_io.cpu_writeData;
          dirty_q[idx][hway] <= 1'b1;
        end
      end
      if (idle && req && !hit) begin
        miss_tag_q <= tag;
        miss_idx_q <= idx;
        vic_q <= victim;
      end
      if (state_q == WRITEBACK && mem_done)
        dirty_q[miss_idx_q][vic_q] <= 1'b0;
      if (state_q == FETCH && mem_done) begin
        data_q[miss_idx_q][vic_q] <= bus_io.mem_readdata;
        tag_q[miss_idx_q][vic_q] <= miss_tag_q;
        valid_q[miss_idx_q][vic_q] <= 1'b1;
        dirty_q[miss_idx_q][vic_q] <= 1'b0;
        lru_q[miss_idx_q] <= !vic_q;
      end
    end
  end
endmodule

// File: tb/tb_dcache_assoc.sv
// tb_dcache_assoc: scoreboard bench; expected memory transactions and load data are queued
// when a request is driven and popped when the cache produces them.
module tb_dcache_assoc;
  typedef struct {
    logic wr;
    logic [5:0] addr;
    logic [31:0] data;
  } txn_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  int cnt = 0;
  int lat = 1;
  logic [5:0] held_addr;
  logic [7:0] gold [256];
  logic [31:0] mem [64];
  txn_t exp_q [$];
  logic [7:0] rd_q [$];
  dcache_assoc_if bus ();
  dcache_assoc dut (.clock_i(clk), .reset_i(reset), .bus_io(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] blk(input logic [5:0] b);
    return {gold[{b, 2'd3}], gold[{b, 2'd2}], gold[{b, 2'd1}], gold[{b, 2'd0}]};
  endfunction
  function automatic txn_t txn(input logic wr, input logic [5:0] addr, input logic [31:0] data);
    txn_t t;
    t.wr = wr;
    t.addr = addr;
    t.data = data;
    return t;
  endfunction
  task automatic init_mem();
    for (int i = 0; i < 256; i++) gold[i] = 8'(i) ^ 8'h5A;
    gold[0] = 8'h11;
    gold[1] = 8'h22;
    gold[2] = 8'h33;
    gold[3] = 8'h44;
    for (int b = 0; b < 64; b++) mem[b] = blk(6'(b));
  endtask
  // One clock: service the memory port just after the edge, then let outputs settle.
  task automatic step();
    txn_t e, a;
    @(posedge clk);
    #1;
    if (reset && (bus.mem_read || bus.mem_write)) begin
      if (cnt > 0) begin
        checks++;
        if (bus.mem_address !== held_addr) begin
          errors++;
          $display("FAIL mem_addr_stable: got %h required %h", bus.mem_address, held_addr);
        end
      end
      held_addr = bus.mem_address;
      if (cnt < lat) begin
        bus.mem_busywait = 1'b1;
        cnt++;
      end else begin
        bus.mem_busywait = 1'b0;
        cnt = 0;
        a = txn(bus.mem_write, bus.mem_address, bus.mem_write ? bus.mem_writedata : 32'h0);
        if (bus.mem_write) mem[bus.mem_address] = bus.mem_writedata;
        else bus.mem_readdata = mem[bus.mem_address];
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL mem_txn: unexpected wr=%b addr=%h data=%h required none", a.wr, a.addr, a.data);
        end else begin
          e = exp_q.pop_front();
          if (a.wr !== e.wr || a.addr !== e.addr || a.data !== e.data) begin
            errors++;
            $display("FAIL mem_txn: got wr=%b addr=%h data=%h required wr=%b addr=%h data=%h",
                     a.wr, a.addr, a.data, e.wr, e.addr, e.data);
          end
        end
      end
    end else begin
      bus.mem_busywait = 1'b0;
      cnt = 0;
    end
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b0;
    bus.read = 1'b0;
    bus.write = 1'b0;
    step();
    step();
    reset = 1'b1;
    lat = 1;
    init_mem();
  endtask
  task automatic access(input logic wr, input logic [7:0] a, input logic [7:0] wd, input int exp_stall, input string nm);
    int n = 0;
    logic [7:0] e;
    bus.write = wr;
    bus.read = !wr;
    bus.address = a;
    bus.cpu_writeData = wd;
    if (!wr) rd_q.push_back(gold[a]);
    #1;
    while (bus.busywait === 1'b1 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (bus.busywait !== 1'b0 || n != exp_stall) begin
      errors++;
      $display("FAIL %s stall: busywait=%b cycles=%0d required busywait=0 cycles=%0d", nm, bus.busywait, n, exp_stall);
    end
    if (!wr) begin
      e = rd_q.pop_front();
      checks++;
      if (bus.cpu_readData !== e) begin
        errors++;
        $display("FAIL %s data: got %h required %h", nm, bus.cpu_readData, e);
      end
    end
    step();
    if (wr) gold[a] = wd;
    bus.read = 1'b0;
    bus.write = 1'b0;
  endtask
  task automatic check_drained(input string nm);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s drained: %0d transactions pending required 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic test_reset();
    reset = 1'b0;
    bus.read = 1'b1;
    bus.write = 1'b0;
    bus.address = 8'h00;
    bus.cpu_writeData = 8'h00;
    bus.mem_busywait = 1'b0;
    bus.mem_readdata = '0;
    step();
    step();
    checks++;
    if (bus.busywait !== 1'b0 || bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 || bus.cpu_readData !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: busywait=%b mem_read=%b mem_write=%b rdata=%h required 0 0 0 00",
               bus.busywait, bus.mem_read, bus.mem_write, bus.cpu_readData);
    end
    bus.read = 1'b0;
    reset = 1'b1;
    init_mem();
    step();
    checks++;
    if (bus.busywait !== 1'b0 || bus.mem_read !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busywait=%b mem_read=%b required 0 0", bus.busywait, bus.mem_read);
    end
  endtask
  task automatic test_read_fill();
    exp_q.push_back(txn(1'b0, 6'h00, 32'h0));
    access(1'b0, 8'h00, 8'h00, 3, "fill_0x00");
    access(1'b0, 8'h03, 8'h00, 0, "hit_0x03");
    check_drained("read_fill");
  endtask
  task automatic test_second_way();
    exp_q.push_back(txn(1'b0, 6'h04, 32'h0));
    access(1'b0, 8'h10, 8'h00, 3, "fill_0x10");
    access(1'b0, 8'h00, 8'h00, 0, "rehit_0x00");
    access(1'b0, 8'h10, 8'h00, 0, "rehit_0x10");
    check_drained("second_way");
  endtask
  task automatic test_lru();
    access(1'b0, 8'h00, 8'h00, 0, "lru_touch_0x00");
    exp_q.push_back(txn(1'b0, 6'h08, 32'h0));
    access(1'b0, 8'h20, 8'h00, 3, "lru_fill_0x20");
    access(1'b0, 8'h00, 8'h00, 0, "lru_kept_0x00");
    exp_q.push_back(txn(1'b0, 6'h04, 32'h0));
    access(1'b0, 8'h10, 8'h00, 3, "lru_evicted_0x10");
    check_drained("lru");
  endtask
  task automatic test_dirty_evict();
    do_reset();
    exp_q.push_back(txn(1'b0, 6'h00, 32'h0));
    access(1'b0, 8'h00, 8'h00, 3, "de_fill_0x00");
    access(1'b1, 8'h01, 8'hAB, 0, "de_write_0x01");
    exp_q.push_back(txn(1'b0, 6'h04, 32'h0));
    access(1'b0, 8'h10, 8'h00, 3, "de_fill_0x10");
    access(1'b0, 8'h10, 8'h00, 0, "de_hit_0x10");
    exp_q.push_back(txn(1'b1, 6'h00, blk(6'h00)));
    exp_q.push_back(txn(1'b0, 6'h08, 32'h0));
    access(1'b0, 8'h20, 8'h00, 5, "de_evict_0x20");
    check_drained("dirty_evict");
    checks++;
    if (mem[0] !== 32'h4433AB11) begin
      errors++;
      $display("FAIL de_writeback_value: got %h required 4433ab11", mem[0]);
    end
  endtask
  task automatic test_write_allocate();
    do_reset();
    exp_q.push_back(txn(1'b0, 6'h11, 32'h0));
    access(1'b1, 8'h46, 8'h5C, 3, "wa_write_0x46");
    access(1'b0, 8'h46, 8'h00, 0, "wa_read_0x46");
    exp_q.push_back(txn(1'b0, 6'h15, 32'h0));
    access(1'b0, 8'h56, 8'h00, 3, "wa_fill_0x56");
    exp_q.push_back(txn(1'b1, 6'h11, blk(6'h11)));
    exp_q.push_back(txn(1'b0, 6'h19, 32'h0));
    access(1'b0, 8'h66, 8'h00, 5, "wa_evict_0x66");
    check_drained("write_allocate");
  endtask
  task automatic test_reset_mid_fetch();
    do_reset();
    lat = 5;
    bus.read = 1'b1;
    bus.address = 8'h84;
    step();
    step();
    checks++;
    if (bus.mem_read !== 1'b1 || bus.mem_address !== 6'h21) begin
      errors++;
      $display("FAIL rmf_fetching: mem_read=%b addr=%h required 1 21", bus.mem_read, bus.mem_address);
    end
    reset = 1'b0;
    step();
    checks++;
    if (bus.mem_read !== 1'b0 || bus.busywait !== 1'b0) begin
      errors++;
      $display("FAIL rmf_abandon: mem_read=%b busywait=%b required 0 0", bus.mem_read, bus.busywait);
    end
    bus.read = 1'b0;
    reset = 1'b1;
    lat = 1;
    step();
    exp_q.push_back(txn(1'b0, 6'h21, 32'h0));
    access(1'b0, 8'h84, 8'h00, 3, "rmf_refetch_0x84");
    check_drained("reset_mid_fetch");
  endtask
  initial begin
    test_reset();
    test_read_fill();
    test_second_way();
    test_lru();
    test_dirty_evict();
    test_write_allocate();
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
